controlador_memoria_dados: RTL and testbench

- Arbitrates the single-port data memory (26-bit word address, 32-bit data, combinational read, write on posedge) between two requesters: the CPU and the DMA/IO port (dma).
- Serialises accesses through a 3-state FSM with a req/ack handshake.
- Registers address, data and write enable toward the memory.
- Registers read data and an out-of-range error flag back to the winning requester.

---
 rtl/controlador_memoria_dados_pkg.sv | 25 ++
 rtl/controlador_memoria_dados_arbitro_rr2.sv | 30 +++
 rtl/controlador_memoria_dados.sv | 129 ++++++++++++
 tb/tb_controlador_memoria_dados.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/controlador_memoria_dados_pkg.sv
// ============================================================================
//  Module   : controlador_memoria_pkg
//  Brief    : Shared types and widths for the data-memory controller.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package controlador_memoria_pkg;

  localparam int LARG_END  = 26;
  localparam int LARG_DADO = 32;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ACESSO  = 2'd1,
    CONCLUI = 2'd2
  } estado_t;

  // Requester IDs double as bit positions in the arbiter request vector.
  localparam logic ID_CPU = 1'b0;
  localparam logic ID_DMA = 1'b1;

endpackage

`default_nettype wire

// File: rtl/controlador_memoria_dados_arbitro_rr2.sv
// ============================================================================
//  Module   : arbitro_rr2
//  Brief    : Combinational two-way picker, round-robin or fixed CPU priority.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbitro_rr2
  import controlador_memoria_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ultimo,
  input  logic       fixa,
  output logic       dono
);

  always_comb begin
    dono = ID_CPU;
    case (req)
      2'b01:   dono = ID_CPU;
      2'b10:   dono = ID_DMA;
      // On a tie the requester that was not served last wins.
      2'b11:   dono = fixa ? ID_CPU : ~ultimo;
      default: dono = ID_CPU;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/controlador_memoria_dados.sv
// ============================================================================
//  Module   : controlador_memoria_dados
//  Brief    : Arbitrates a single-port data memory between CPU and DMA.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module controlador_memoria_dados
  import controlador_memoria_pkg::*;
#(
  parameter int PROFUNDIDADE    = 31,
  parameter bit PRIORIDADE_FIXA = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [LARG_END-1:0]  cpu_endereco,
  input  logic [LARG_DADO-1:0] cpu_dado,
  output logic                 cpu_ack,
  output logic [LARG_DADO-1:0] cpu_dado_lido,
  input  logic                 dma_req,
  input  logic                 dma_we,
  input  logic [LARG_END-1:0]  dma_endereco,
  input  logic [LARG_DADO-1:0] dma_dado,
  output logic                 dma_ack,
  output logic [LARG_DADO-1:0] dma_dado_lido,
  output logic                 erro,
  output logic                 ocupado,
  output logic [LARG_END-1:0]  mem_endereco,
  output logic                 mem_memWrite,
  output logic [LARG_DADO-1:0] mem_dado_Escrito,
  input  logic [LARG_DADO-1:0] mem_dado_Lido
);

  localparam logic [LARG_END-1:0] c_LIMITE = LARG_END'(PROFUNDIDADE);

  estado_t              estado_q;
  logic                 dono_q;
  logic                 ultimo_q;
  logic                 we_q;
  logic [LARG_END-1:0]  endereco_q;
  logic [LARG_DADO-1:0] dado_q;
  logic                 cpu_ack_q;
  logic                 dma_ack_q;
  logic                 erro_q;
  logic [LARG_DADO-1:0] cpu_lido_q;
  logic [LARG_DADO-1:0] dma_lido_q;

  logic                 dono_d;
  logic                 em_faixa;
  logic [LARG_DADO-1:0] lido_d;

  arbitro_rr2 u_arbitro (
    .req    ({dma_req, cpu_req}),
    .ultimo (ultimo_q),
    .fixa   (PRIORIDADE_FIXA),
    .dono   (dono_d)
  );

  assign em_faixa = (endereco_q < c_LIMITE);
  assign lido_d   = em_faixa ? mem_dado_Lido : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      dono_q     <= ID_CPU;
      ultimo_q   <= ID_DMA;
      we_q       <= 1'b0;
      endereco_q <= '0;
      dado_q     <= '0;
      cpu_ack_q  <= 1'b0;
      dma_ack_q  <= 1'b0;
      erro_q     <= 1'b0;
      cpu_lido_q <= '0;
      dma_lido_q <= '0;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (cpu_req || dma_req) begin
            dono_q   <= dono_d;
            ultimo_q <= dono_d;
            if (dono_d == ID_DMA) begin
              endereco_q <= dma_endereco;
              dado_q     <= dma_dado;
              we_q       <= dma_we;
            end else begin
              endereco_q <= cpu_endereco;
              dado_q     <= cpu_dado;
              we_q       <= cpu_we;
            end
            estado_q <= ACESSO;
          end
        end
        ACESSO: begin
          if (!we_q) begin
            if (dono_q == ID_DMA) dma_lido_q <= lido_d;
            else                  cpu_lido_q <= lido_d;
          end
          cpu_ack_q <= (dono_q == ID_CPU);
          dma_ack_q <= (dono_q == ID_DMA);
          erro_q    <= ~em_faixa;
          estado_q  <= CONCLUI;
        end
        CONCLUI: begin
          cpu_ack_q <= 1'b0;
          dma_ack_q <= 1'b0;
          erro_q    <= 1'b0;
          estado_q  <= OCIOSO;
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  // The write strobe is combinational so a reset during ACESSO can still kill it.
  assign mem_memWrite     = (estado_q == ACESSO) && we_q && em_faixa && !reset;
  assign mem_endereco     = endereco_q;
  assign mem_dado_Escrito = dado_q;
  assign ocupado          = (estado_q != OCIOSO);
  assign cpu_ack          = cpu_ack_q;
  assign dma_ack          = dma_ack_q;
  assign erro             = erro_q;
  assign cpu_dado_lido    = cpu_lido_q;
  assign dma_dado_lido    = dma_lido_q;

endmodule

`default_nettype wire

// File: tb/tb_controlador_memoria_dados.sv
// ============================================================================
//  Module   : tb_controlador_memoria_dados
//  Brief    : Self-checking bench for controlador_memoria_dados.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_controlador_memoria_dados;
  import controlador_memoria_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [25:0] cpu_endereco, dma_endereco;
  logic [31:0] cpu_dado, dma_dado;
  logic        cpu_ack, dma_ack, erro, ocupado, mem_memWrite;
  logic [31:0] cpu_dado_lido, dma_dado_lido, mem_dado_Escrito, mem_dado_Lido;
  logic [25:0] mem_endereco;

  logic        f_cpu_req, f_dma_req, f_cpu_ack, f_dma_ack, f_erro, f_ocupado, f_memWrite;
  logic [31:0] f_cpu_lido, f_dma_lido, f_escrito;
  logic [25:0] f_endereco;
  logic [25:0] f_zero_end = '0;
  logic [31:0] f_zero_dado = '0;
  logic        f_zero = 1'b0;

  logic [31:0] mem [0:63];
  logic        carrega;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        dono;
    logic [31:0] dado;
    logic        erro;
  } esperado_t;
  esperado_t fila[$];

  always #5 clock = ~clock;

  controlador_memoria_dados #(.PROFUNDIDADE(31), .PRIORIDADE_FIXA(1'b0)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_endereco(cpu_endereco), .cpu_dado(cpu_dado),
    .cpu_ack(cpu_ack), .cpu_dado_lido(cpu_dado_lido),
    .dma_req(dma_req), .dma_we(dma_we), .dma_endereco(dma_endereco), .dma_dado(dma_dado),
    .dma_ack(dma_ack), .dma_dado_lido(dma_dado_lido),
    .erro(erro), .ocupado(ocupado),
    .mem_endereco(mem_endereco), .mem_memWrite(mem_memWrite),
    .mem_dado_Escrito(mem_dado_Escrito), .mem_dado_Lido(mem_dado_Lido)
  );

  controlador_memoria_dados #(.PROFUNDIDADE(31), .PRIORIDADE_FIXA(1'b1)) u_fixa (
    .clock(clock), .reset(reset),
    .cpu_req(f_cpu_req), .cpu_we(f_zero), .cpu_endereco(f_zero_end), .cpu_dado(f_zero_dado),
    .cpu_ack(f_cpu_ack), .cpu_dado_lido(f_cpu_lido),
    .dma_req(f_dma_req), .dma_we(f_zero), .dma_endereco(f_zero_end), .dma_dado(f_zero_dado),
    .dma_ack(f_dma_ack), .dma_dado_lido(f_dma_lido),
    .erro(f_erro), .ocupado(f_ocupado),
    .mem_endereco(f_endereco), .mem_memWrite(f_memWrite),
    .mem_dado_Escrito(f_escrito), .mem_dado_Lido(f_zero_dado)
  );

  // Memory model: combinational read, write on posedge; a few words preloaded.
  assign mem_dado_Lido = mem[mem_endereco[5:0]];

  always @(posedge clock) begin
    if (carrega) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[9]  <= 32'h0909_0909;
      mem[31] <= 32'hBAD0_BAD0;
    end else if (mem_memWrite) begin
      mem[mem_endereco[5:0]] <= mem_dado_Escrito;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic run_txn(input logic quem, input logic we, input logic [25:0] ender,
                         input logic [31:0] dado, output int lat, output logic [31:0] lido,
                         output logic erro_v, output logic ack_errado, output logic viu_escrita);
    lat = -1; lido = '0; erro_v = 1'b0; ack_errado = 1'b0; viu_escrita = 1'b0;
    if (quem == ID_CPU) begin
      cpu_req = 1'b1; cpu_we = we; cpu_endereco = ender; cpu_dado = dado;
    end else begin
      dma_req = 1'b1; dma_we = we; dma_endereco = ender; dma_dado = dado;
    end
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock); #1;
      if (mem_memWrite) viu_escrita = 1'b1;
      if ((quem == ID_CPU) ? dma_ack : cpu_ack) ack_errado = 1'b1;
      if ((quem == ID_CPU) ? cpu_ack : dma_ack) begin
        lat    = c;
        lido   = (quem == ID_CPU) ? cpu_dado_lido : dma_dado_lido;
        erro_v = erro;
        break;
      end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    checks++; if (ocupado !== 1'b0) $display("FAIL reset_ocupado: got %b want 0", ocupado); else passed++;
    checks++; if (cpu_ack !== 1'b0 || dma_ack !== 1'b0) $display("FAIL reset_ack: got %b%b want 00", cpu_ack, dma_ack); else passed++;
    checks++; if (erro !== 1'b0) $display("FAIL reset_erro: got %b want 0", erro); else passed++;
    checks++; if (mem_memWrite !== 1'b0) $display("FAIL reset_memWrite: got %b want 0", mem_memWrite); else passed++;
    checks++; if (mem_endereco !== 26'h0 || mem_dado_Escrito !== 32'h0) $display("FAIL reset_mem_regs: got %h/%h want 0/0", mem_endereco, mem_dado_Escrito); else passed++;
    checks++; if (cpu_dado_lido !== 32'h0 || dma_dado_lido !== 32'h0) $display("FAIL reset_lido: got %h/%h want 0/0", cpu_dado_lido, dma_dado_lido); else passed++;
  endtask

  task automatic test_cpu_write_read();
    int lat; logic [31:0] lido; logic e, errado, escr; esperado_t x;
    fila.push_back('{ID_CPU, 32'h0, 1'b0});
    run_txn(ID_CPU, 1'b1, 26'd5, 32'hDEAD_BEEF, lat, lido, e, errado, escr);
    x = fila.pop_front();
    checks++; if (lat != 2) $display("FAIL cpu_wr_latency: got %0d want 2", lat); else passed++;
    checks++; if (lido !== x.dado) $display("FAIL cpu_wr_lido: got %h want %h", lido, x.dado); else passed++;
    checks++; if (e !== x.erro) $display("FAIL cpu_wr_erro: got %b want %b", e, x.erro); else passed++;
    checks++; if (mem[5] !== 32'hDEAD_BEEF) $display("FAIL cpu_wr_mem5: got %h want deadbeef", mem[5]); else passed++;
    checks++; if (errado !== 1'b0) $display("FAIL cpu_wr_dma_ack: got %b want 0", errado); else passed++;
    fila.push_back('{ID_CPU, 32'hDEAD_BEEF, 1'b0});
    run_txn(ID_CPU, 1'b0, 26'd5, 32'h0, lat, lido, e, errado, escr);
    x = fila.pop_front();
    checks++; if (lat != 2) $display("FAIL cpu_rd_latency: got %0d want 2", lat); else passed++;
    checks++; if (lido !== x.dado) $display("FAIL cpu_rd_lido: got %h want %h", lido, x.dado); else passed++;
    checks++; if (e !== x.erro) $display("FAIL cpu_rd_erro: got %b want %b", e, x.erro); else passed++;
    checks++; if (errado !== 1'b0) $display("FAIL cpu_rd_dma_ack: got %b want 0", errado); else passed++;
    repeat (2) @(posedge clock); #1;
    checks++; if (cpu_dado_lido !== 32'hDEAD_BEEF) $display("FAIL cpu_lido_hold: got %h want deadbeef", cpu_dado_lido); else passed++;
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] lido; logic e, errado, escr; esperado_t x;
    fila.push_back('{ID_DMA, 32'h0, 1'b1});
    run_txn(ID_DMA, 1'b1, 26'd31, 32'h1234_5678, lat, lido, e, errado, escr);
    x = fila.pop_front();
    checks++; if (lat != 2) $display("FAIL oor_wr_latency: got %0d want 2", lat); else passed++;
    checks++; if (escr !== 1'b0) $display("FAIL oor_wr_memWrite: got %b want 0", escr); else passed++;
    checks++; if (e !== x.erro) $display("FAIL oor_wr_erro: got %b want %b", e, x.erro); else passed++;
    checks++; if (mem[31] !== 32'hBAD0_BAD0) $display("FAIL oor_wr_mem31: got %h want bad0bad0", mem[31]); else passed++;
    fila.push_back('{ID_DMA, 32'h0, 1'b1});
    run_txn(ID_DMA, 1'b0, 26'd31, 32'h0, lat, lido, e, errado, escr);
    x = fila.pop_front();
    checks++; if (lido !== x.dado) $display("FAIL oor_rd_lido: got %h want %h", lido, x.dado); else passed++;
    checks++; if (e !== x.erro) $display("FAIL oor_rd_erro: got %b want %b", e, x.erro); else passed++;
    fila.push_back('{ID_DMA, 32'h0, 1'b0});
    run_txn(ID_DMA, 1'b1, 26'd30, 32'h3030_3030, lat, lido, e, errado, escr);
    x = fila.pop_front();
    checks++; if (escr !== 1'b1 || e !== x.erro) $display("FAIL edge_wr30: got write=%b erro=%b want write=1 erro=%b", escr, e, x.erro); else passed++;
    fila.push_back('{ID_DMA, 32'h3030_3030, 1'b0});
    run_txn(ID_DMA, 1'b0, 26'd30, 32'h0, lat, lido, e, errado, escr);
    x = fila.pop_front();
    checks++; if (lido !== x.dado || e !== x.erro) $display("FAIL edge_rd30: got %h/%b want %h/%b", lido, e, x.dado, x.erro); else passed++;
    checks++; if (errado !== 1'b0) $display("FAIL edge_rd30_cpu_ack: got %b want 0", errado); else passed++;
  endtask

  task automatic test_reset_mid_access();
    int lat; logic [31:0] lido; logic e, errado, escr; esperado_t x;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_endereco = 26'd30; cpu_dado = 32'hA5A5_A5A5;
    @(posedge clock); #1;
    checks++; if (ocupado !== 1'b1) $display("FAIL rst_mid_in_acesso: got ocupado=%b want 1", ocupado); else passed++;
    reset = 1'b1; cpu_req = 1'b0;
    #1;
    checks++; if (mem_memWrite !== 1'b0) $display("FAIL rst_mid_memWrite: got %b want 0", mem_memWrite); else passed++;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if (ocupado !== 1'b0) $display("FAIL rst_mid_ocupado: got %b want 0", ocupado); else passed++;
    checks++; if (cpu_ack !== 1'b0 || dma_ack !== 1'b0) $display("FAIL rst_mid_ack: got %b%b want 00", cpu_ack, dma_ack); else passed++;
    checks++; if (cpu_dado_lido !== 32'h0 || dma_dado_lido !== 32'h0) $display("FAIL rst_mid_lido: got %h/%h want 0/0", cpu_dado_lido, dma_dado_lido); else passed++;
    fila.push_back('{ID_CPU, 32'h3030_3030, 1'b0});
    run_txn(ID_CPU, 1'b0, 26'd30, 32'h0, lat, lido, e, errado, escr);
    x = fila.pop_front();
    checks++; if (lido !== x.dado) $display("FAIL rst_mid_readback: got %h want %h", lido, x.dado); else passed++;
  endtask

  task automatic test_input_change();
    bit visto = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_endereco = 26'd7; cpu_dado = 32'h7777_7777;
    @(posedge clock); #1;
    cpu_endereco = 26'd9; cpu_dado = 32'h9999_9999;
    checks++; if (mem_endereco !== 26'd7) $display("FAIL chg_mem_endereco: got %0d want 7", mem_endereco); else passed++;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      if (cpu_ack) begin visto = 1; break; end
    end
    cpu_req = 1'b0;
    checks++; if (visto !== 1'b1) $display("FAIL chg_ack_timeout: got %b want 1", visto); else passed++;
    @(posedge clock); #1;
    checks++; if (mem[7] !== 32'h7777_7777) $display("FAIL chg_mem7: got %h want 77777777", mem[7]); else passed++;
    checks++; if (mem[9] !== 32'h0909_0909) $display("FAIL chg_mem9: got %h want 09090909", mem[9]); else passed++;
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      @(posedge clock); #1;
      checks++;
      if (ocupado !== 1'b0 || cpu_ack !== 1'b0 || dma_ack !== 1'b0 || mem_memWrite !== 1'b0)
        $display("FAIL idle_cycle%0d: got ocupado=%b acks=%b%b memWrite=%b want all 0", c, ocupado, cpu_ack, dma_ack, mem_memWrite);
      else passed++;
    end
  endtask

  task automatic test_round_robin();
    int n = 0, ultimo_ack = -1; logic obs; esperado_t x;
    reset = 1'b1;
    repeat (2) @(posedge clock); #1;
    reset = 1'b0;
    fila.push_back('{ID_CPU, 32'h0, 1'b0}); fila.push_back('{ID_DMA, 32'h0, 1'b0});
    fila.push_back('{ID_CPU, 32'h0, 1'b0}); fila.push_back('{ID_DMA, 32'h0, 1'b0});
    cpu_we = 1'b0; dma_we = 1'b0; cpu_endereco = 26'd0; dma_endereco = 26'd0;
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int c = 1; c <= 30 && n < 4; c++) begin
      @(posedge clock); #1;
      if (cpu_ack || dma_ack) begin
        obs = dma_ack ? ID_DMA : ID_CPU;
        x = fila.pop_front();
        checks++; if ((cpu_ack && dma_ack) || obs !== x.dono) $display("FAIL rr_grant%0d: got cpu_ack=%b dma_ack=%b want dono=%b", n, cpu_ack, dma_ack, x.dono); else passed++;
        if (ultimo_ack >= 0) begin
          checks++; if (c - ultimo_ack != 3) $display("FAIL rr_spacing%0d: got %0d want 3", n, c - ultimo_ack); else passed++;
        end
        ultimo_ack = c;
        n++;
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    checks++; if (n != 4) $display("FAIL rr_count: got %0d want 4", n); else passed++;
    fila.delete();
    repeat (2) @(posedge clock); #1;
  endtask

  task automatic test_fixed_priority();
    int n = 0;
    reset = 1'b1;
    repeat (2) @(posedge clock); #1;
    reset = 1'b0;
    f_cpu_req = 1'b1; f_dma_req = 1'b1;
    for (int c = 1; c <= 30 && n < 4; c++) begin
      @(posedge clock); #1;
      if (f_cpu_ack || f_dma_ack) begin
        checks++; if (f_cpu_ack !== 1'b1 || f_dma_ack !== 1'b0) $display("FAIL fixa_grant%0d: got cpu_ack=%b dma_ack=%b want 1/0", n, f_cpu_ack, f_dma_ack); else passed++;
        n++;
      end
    end
    f_cpu_req = 1'b0; f_dma_req = 1'b0;
    checks++; if (n != 4) $display("FAIL fixa_count: got %0d want 4", n); else passed++;
    repeat (2) @(posedge clock); #1;
  endtask

  initial begin
    reset = 1'b1; carrega = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_endereco = '0; cpu_dado = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_endereco = '0; dma_dado = '0;
    f_cpu_req = 1'b0; f_dma_req = 1'b0;
    repeat (2) @(posedge clock); #1;
    reset = 1'b0; carrega = 1'b0;
    test_reset();
    test_cpu_write_read();
    test_out_of_range();
    test_reset_mid_access();
    test_input_change();
    test_idle();
    test_round_robin();
    test_fixed_priority();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
